// File: rtl/tw_horizontal_tx.sv
// Buffers ENTRIES twiddle words and sends them to the ROM as high halves, then low halves.
// Optional build macro TW_TX_AUTOSTART_EN launches the burst as soon as the buffer is full.
module tw_horizontal_tx #(
    parameter int P_WIDTH = 128,
    parameter int HDW     = 64,
    parameter int ENTRIES = 4
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [P_WIDTH-1:0] in_data,
    output logic               in_ready,
    input  logic               start,
    output logic [1:0]         ROM1_w,
    output logic [HDW-1:0]     horizontal_data_out,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(ENTRIES + 1);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(ENTRIES);
    localparam logic [IW-1:0] IDX_LAST = IW'(ENTRIES - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEND_HI = 2'd1;
    localparam logic [1:0] SEND_LO = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]         state_r;
    logic [1:0]         state_s;
    logic [IW-1:0]      idx_r;
    logic [IW-1:0]      idx_s;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      cnt_s;
    logic [P_WIDTH-1:0] buf_r [ENTRIES];
    logic               accept_s;
    logic               launch_s;
    logic [1:0]         rom_w_s;
    logic [HDW-1:0]     hdo_s;
    logic               in_ready_r;
    logic [1:0]         rom_w_r;
    logic [HDW-1:0]     hdo_r;
    logic               busy_r;
    logic               done_r;

`ifdef TW_TX_AUTOSTART_EN
    logic unused_start_s;
    assign unused_start_s = start;
    assign launch_s       = 1'b1;
`else
    assign launch_s       = start;
`endif

    // in_ready_r already equals "IDLE and not full", so accepts only happen in IDLE
    assign accept_s = in_valid && in_ready_r;

    // Next-state, index and fill-count logic; launch is judged on the registered count
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    cnt_s = cnt_r + CW'(1);
                end else begin
                    cnt_s = cnt_r;
                end
                if (launch_s && (cnt_r == CNT_FULL)) begin
                    state_s = SEND_HI;
                    idx_s   = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND_HI: begin
                if (idx_r == IDX_LAST) begin
                    state_s = SEND_LO;
                    idx_s   = '0;
                end else begin
                    idx_s   = idx_r + IW'(1);
                end
            end
            SEND_LO: begin
                if (idx_r == IDX_LAST) begin
                    state_s = DONE;
                    idx_s   = '0;
                end else begin
                    idx_s   = idx_r + IW'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
            default: begin
                state_s = IDLE;
                idx_s   = '0;
                cnt_s   = '0;
            end
        endcase
    end

    // Output values for the upcoming state so the ROM strobes are registered without extra latency
    always_comb begin
        rom_w_s = 2'd0;
        hdo_s   = '0;
        case (state_s)
            SEND_HI: begin
                rom_w_s = 2'd1;
                hdo_s   = buf_r[idx_s][P_WIDTH-1:HDW];
            end
            SEND_LO: begin
                rom_w_s = 2'd2;
                hdo_s   = buf_r[idx_s][HDW-1:0];
            end
            default: begin
                rom_w_s = 2'd0;
                hdo_s   = '0;
            end
        endcase
    end

    // Control state and registered outputs
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            cnt_r      <= '0;
            in_ready_r <= 1'b1;
            rom_w_r    <= 2'd0;
            hdo_r      <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            cnt_r      <= cnt_s;
            in_ready_r <= (state_s == IDLE) && (cnt_s < CNT_FULL);
            rom_w_r    <= rom_w_s;
            hdo_r      <= hdo_s;
            busy_r     <= (state_s == SEND_HI) || (state_s == SEND_LO);
            done_r     <= (state_s == DONE);
        end
    end

    // Word buffer; contents are don't-care after reset and frozen outside IDLE
    always_ff @(posedge CLK) begin
        if (accept_s) begin
            buf_r[cnt_r[IW-1:0]] <= in_data;
        end
    end

    assign in_ready            = in_ready_r;
    assign ROM1_w              = rom_w_r;
    assign horizontal_data_out = hdo_r;
    assign busy                = busy_r;
    assign done                = done_r;

endmodule

// File: tb/tb_tw_horizontal_tx.sv
// Scoreboard bench for tw_horizontal_tx: expected ROM cycles are queued at launch and
// compared every falling edge while the burst runs.
module tb_tw_horizontal_tx;

    localparam int PW = 128;
    localparam int HW = 64;
    localparam int N  = 4;

    logic          CLK = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          in_ready;
    logic          start = 1'b0;
    logic [1:0]    ROM1_w;
    logic [HW-1:0] horizontal_data_out;
    logic          busy;
    logic          done;

    typedef struct packed {
        logic [1:0]    w;
        logic [HW-1:0] d;
        logic          dn;
    } exp_t;

    exp_t          sb_q[$];
    logic [PW-1:0] mbuf [N];
    int            model_cnt = 0;
    int            tests_run = 0;
    int            tests_failed = 0;
    bit            sb_go = 1'b0;

    tw_horizontal_tx #(.P_WIDTH(PW), .HDW(HW), .ENTRIES(N)) dut (
        .CLK                 (CLK),
        .rst_n               (rst_n),
        .in_valid            (in_valid),
        .in_data             (in_data),
        .in_ready            (in_ready),
        .start               (start),
        .ROM1_w              (ROM1_w),
        .horizontal_data_out (horizontal_data_out),
        .busy                (busy),
        .done                (done)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Compare one queued ROM cycle per falling edge while a burst is armed
    always @(negedge CLK) begin
        exp_t e;
        if (sb_go && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("rom1_w", 128'(ROM1_w), 128'(e.w));
            check_eq("hdata", 128'(horizontal_data_out), 128'(e.d));
            check_eq("done", 128'(done), 128'(e.dn));
            check_eq("busy", 128'(busy), 128'(e.w != 2'd0));
            check_eq("in_ready_burst", 128'(in_ready), 128'(0));
        end
    end

    task automatic push_burst();
        for (int i = 0; i < N; i++) sb_q.push_back('{2'd1, mbuf[i][PW-1:HW], 1'b0});
        for (int i = 0; i < N; i++) sb_q.push_back('{2'd2, mbuf[i][HW-1:0], 1'b0});
        sb_q.push_back('{2'd0, {HW{1'b0}}, 1'b1});
    endtask

    // Offer one word for one cycle; in_valid is left high for back-to-back offers
    task automatic offer(input logic [PW-1:0] w);
        @(negedge CLK);
        in_valid = 1'b1;
        in_data  = w;
        check_eq("in_ready", 128'(in_ready), 128'(model_cnt < N));
        if (model_cnt < N) begin
            mbuf[model_cnt] = w;
            model_cnt++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) offer({$urandom, $urandom, $urandom, $urandom});
        in_valid = 1'b0;
    endtask

    task automatic wait_burst();
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge CLK);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
        if (sb_q.size() != 0) begin
            check_eq("burst_timeout", 128'(sb_q.size()), 128'(0));
            sb_q.delete();
        end
        sb_go     = 1'b0;
        model_cnt = 0;
    endtask

    task automatic launch(input bit hold);
        push_burst();
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) start = 1'b0;
        sb_go = 1'b1;
        wait_burst();
    endtask

    task automatic expect_idle(input int n, input logic rdy, input string tag);
        repeat (n) begin
            @(negedge CLK);
            check_eq({tag, "_w"}, 128'(ROM1_w), 128'(0));
            check_eq({tag, "_busy"}, 128'(busy), 128'(0));
            check_eq({tag, "_done"}, 128'(done), 128'(0));
            check_eq({tag, "_rdy"}, 128'(in_ready), 128'(rdy));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_w", 128'(ROM1_w), 128'(0));
        check_eq("rst_data", 128'(horizontal_data_out), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_done", 128'(done), 128'(0));
        check_eq("rst_rdy", 128'(in_ready), 128'(1));
        @(posedge CLK);
        #1;
        rst_n = 1'b1;

`ifdef TW_TX_AUTOSTART_EN
        fill(N);
        push_burst();
        @(negedge CLK);
        check_eq("auto_wait", 128'(ROM1_w), 128'(0));
        @(posedge CLK);
        #1;
        sb_go = 1'b1;
        wait_burst();
        expect_idle(3, 1'b1, "auto_after");
`else
        // Reference fill: W0 carries 1 in both halves
        offer({64'h0000000000000001, 64'h0000000000000001});
        offer({64'h1111111111111111, 64'haaaaaaaaaaaaaaaa});
        offer({64'h2222222222222222, 64'hbbbbbbbbbbbbbbbb});
        offer({64'h3333333333333333, 64'hcccccccccccccccc});
        in_valid = 1'b0;
        launch(1'b0);
        expect_idle(2, 1'b1, "post_burst");

        // Start on a partly filled buffer is ignored, then the fill completes
        fill(2);
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        expect_idle(3, 1'b1, "partial_start");
        fill(2);
        launch(1'b0);

        // Continuous offer of six words; start held through the burst and DONE
        for (int i = 0; i < 6; i++) offer({$urandom, $urandom, $urandom, $urandom});
        launch(1'b1);
        expect_idle(3, 1'b1, "hold_start");

        // Start coinciding with the filling accept is ignored
        fill(3);
        start = 1'b1;
        offer({$urandom, $urandom, $urandom, $urandom});
        start    = 1'b0;
        in_valid = 1'b0;
        expect_idle(2, 1'b0, "same_cycle_start");
        launch(1'b0);

        // Reset during the third low-half cycle aborts the burst
        fill(N);
        push_burst();
        void'(sb_q.pop_back());
        void'(sb_q.pop_back());
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        sb_go = 1'b1;
        repeat (7) @(negedge CLK);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_w", 128'(ROM1_w), 128'(0));
        check_eq("abort_data", 128'(horizontal_data_out), 128'(0));
        check_eq("abort_busy", 128'(busy), 128'(0));
        check_eq("abort_done", 128'(done), 128'(0));
        check_eq("abort_sb_left", 128'(sb_q.size()), 128'(0));
        sb_q.delete();
        sb_go     = 1'b0;
        model_cnt = 0;
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        start = 1'b1;
        expect_idle(4, 1'b1, "after_abort");
        start = 1'b0;
        fill(N);
        launch(1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
